// File: rtl/button_event_pipeline.sv
// Debounce a synchronized button, detect presses and align events to a game-timer tick.
// Optional auto-repeat is enabled with `define BUTTON_EVENT_PIPELINE_AUTOREPEAT_EN.
module button_event_pipeline #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 2000,
    parameter int REPEAT_PERIOD   = 500
) (
    input  logic clock,
    input  logic resetn,
    input  logic in_sync,
    input  logic tick_input,
    output logic out_level,
    output logic key_pulse,
    output logic button
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    // Parameter legality is checked at elaboration; no hardware results.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range 2..65535");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be positive");
    end

    logic [CW-1:0] db_cnt;
    logic          prev_level;
    logic          pending;
    logic          evt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            db_cnt    <= '0;
            out_level <= 1'b0;
        end else if (in_sync != out_level) begin
            if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                out_level <= ~out_level;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + CW'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prev_level <= 1'b0;
        end else begin
            prev_level <= out_level;
        end
    end

    // Rising edge only; both terms are registers so the pulse is glitch-free.
    assign key_pulse = out_level & ~prev_level;

`ifdef BUTTON_EVENT_PIPELINE_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);

    logic [RW-1:0] rpt_cnt;
    logic          rpt_armed;
    logic          rpt_fire;

    // rpt_cnt is 0 in the key_pulse cycle, so the first fire lands REPEAT_DELAY clocks after the rise.
    assign rpt_fire = out_level &
                      (rpt_cnt == (rpt_armed ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (!out_level) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt   <= RW'(1);
            rpt_armed <= 1'b1;
        end else begin
            rpt_cnt <= rpt_cnt + RW'(1);
        end
    end

    assign evt = key_pulse | rpt_fire;
`else
    assign evt = key_pulse;
`endif

    // An event arriving on a tick clock goes straight to button and never touches pending.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pending <= 1'b0;
            button  <= 1'b0;
        end else if (tick_input) begin
            button  <= pending | evt;
            pending <= 1'b0;
        end else begin
            pending <= pending | evt;
            button  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_button_event_pipeline.sv
// Scoreboard bench for button_event_pipeline: expected key/button cycles are queued at stimulus time.
// Define BUTTON_EVENT_PIPELINE_AUTOREPEAT_EN to also exercise auto-repeat.
module tb_button_event_pipeline;

    localparam int DB = 16;
    localparam int RD = 200;
    localparam int RP = 50;

    logic clock = 1'b0;
    logic resetn;
    logic in_sync;
    logic tick_input;
    logic out_level;
    logic key_pulse;
    logic button;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tick_p   = 100;
    int last_btn = -1;
    int key_q[$];
    int btn_q[$];

    button_event_pipeline #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_sync   (in_sync),
        .tick_input(tick_input),
        .out_level (out_level),
        .key_pulse (key_pulse),
        .button    (button)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every key_pulse/button high cycle must match the head of its queue.
    always @(negedge clock) begin
        if (resetn) begin
            if (key_pulse) begin
                if (key_q.size() == 0) check("key_unexpected", cyc, -1);
                else check("key_cycle", cyc, key_q.pop_front());
            end
            if (button) begin
                if (btn_q.size() == 0) check("button_unexpected", cyc, -1);
                else check("button_cycle", cyc, btn_q.pop_front());
            end
        end
    end

    // Ticks are sampled on edges whose number is a multiple of tick_p.
    task automatic step();
        @(posedge clock);
        cyc++;
        #1;
        tick_input = ((cyc + 1) % tick_p == 0);
    endtask

    // An event visible in cycle t is seen by the first tick edge at or after t+1.
    task automatic add_btn(input int t);
        int b;
        b = ((t + tick_p) / tick_p) * tick_p;
        if (b != last_btn) begin
            btn_q.push_back(b);
            last_btn = b;
        end
    endtask

    task automatic wait_mod(input int m);
        while (cyc % tick_p != m) step();
    endtask

    // Hold in_sync high for 'hold' clocks, then low for 'gap' clocks, checking out_level each clock.
    task automatic press(input int hold, input int gap);
        int s;
        int r;
        int fall;
        s    = cyc;
        r    = s + DB;
        fall = s + hold + DB;
        in_sync = 1'b1;
        if (hold >= DB) begin
            key_q.push_back(r);
            add_btn(r);
`ifdef BUTTON_EVENT_PIPELINE_AUTOREPEAT_EN
            for (int t = r + RD; t < fall; t += RP) add_btn(t);
`endif
        end
        for (int i = 1; i <= hold + gap; i++) begin
            step();
            if (i == hold) in_sync = 1'b0;
            check("out_level", int'(out_level), int'(hold >= DB && cyc >= r && cyc < fall));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (key_q.size() != 0 || btn_q.size() != 0); i++) step();
        step();
        check("key_queue_empty", key_q.size(), 0);
        check("button_queue_empty", btn_q.size(), 0);
    endtask

    initial begin
        resetn     = 1'b0;
        in_sync    = 1'b0;
        tick_input = 1'b0;
        repeat (3) step();
        check("reset_out_level", int'(out_level), 0);
        check("reset_key_pulse", int'(key_pulse), 0);
        check("reset_button", int'(button), 0);
        resetn = 1'b1;
        step();

        // Glitches shorter than the debounce window, then a real press.
        press(2, 1);
        press(3, 1);
        press(50, 30);
        drain();

        // Key pulse 30 clocks after a tick.
        wait_mod(14);
        press(20, 30);
        drain();

        // Two presses between the same pair of ticks collapse to one button.
        wait_mod(0);
        press(20, 20);
        press(20, 20);
        drain();

        // Key pulse coincides with the tick.
        wait_mod(83);
        press(20, 30);
        drain();

        // Reset with a pending event and a partial debounce count.
        wait_mod(0);
        in_sync = 1'b1;
        key_q.push_back(cyc + DB);
        repeat (20) step();
        in_sync = 1'b0;
        repeat (DB) step();
        in_sync = 1'b1;
        repeat (10) step();
        resetn  = 1'b0;
        in_sync = 1'b0;
        #1;
        check("midreset_out_level", int'(out_level), 0);
        check("midreset_key_pulse", int'(key_pulse), 0);
        check("midreset_button", int'(button), 0);
        step();
        resetn = 1'b1;
        repeat (250) step();
        check("post_reset_button_queue", btn_q.size(), 0);
        check("post_reset_key_queue", key_q.size(), 0);
        press(40, 30);
        drain();

`ifdef BUTTON_EVENT_PIPELINE_AUTOREPEAT_EN
        // Auto-repeat with 10-clock ticks and a 400-clock hold.
        tick_p = 10;
        wait_mod(3);
        press(400, 30);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_event_pipeline.md
BUTTON_EVENT_PIPELINE -- requirements
Module: button_event_pipeline

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable clocks needed to accept a level change; legal range 2..65535.
REQ-002 SHALL have parameter REPEAT_DELAY, default 2000: held clocks before the first auto-repeat edge; used only with the macro.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 500: clocks between later auto-repeat edges; used only with the macro.
REQ-004 SHALL have port: clock  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: in_sync  input  1  button level, already synchronized to clock; active high.
REQ-007 SHALL have port: tick_input  input  1  one-clock pacing strobe from the game timer.
REQ-008 SHALL have port: out_level  output  1  debounced button level, registered.
REQ-009 SHALL have port: key_pulse  output  1  one-clock rising-edge pulse of out_level.
REQ-010 SHALL have port: button  output  1  tick-aligned one-clock event pulse, registered.

Function
REQ-011 SHALL keep a debounce counter of width clog2(DEBOUNCE_CYCLES)+1; it increments each clock in_sync != out_level and clears to 0 on any clock in_sync == out_level.
REQ-012 SHALL toggle out_level and clear the counter on the clock edge where in_sync != out_level and counter == DEBOUNCE_CYCLES-1; out_level therefore follows a stable change DEBOUNCE_CYCLES clocks after in_sync first differs.
REQ-013 SHALL leave out_level unchanged for any in_sync pulse or glitch shorter than DEBOUNCE_CYCLES clocks.
REQ-014 SHALL register out_level into prev_level each clock; key_pulse = out_level AND NOT prev_level, high exactly in the first cycle out_level is 1.
REQ-015 SHALL NOT assert key_pulse on a falling edge of out_level.
REQ-016 SHALL hold a pending flag; on a clock edge with tick_input=0, pending <= pending OR key_pulse and button <= 0.
REQ-017 SHALL, on a clock edge with tick_input=1, set button <= pending OR key_pulse and clear pending to 0; a key_pulse coinciding with tick_input is consumed by that tick.
REQ-018 SHALL collapse any number of key_pulse events between two ticks into one button pulse.
REQ-019 SHALL keep button high for exactly one clock per tick, never on two consecutive clocks unless tick_input is high on two consecutive clocks with a new event each time.
REQ-020 SHALL treat tick_input held high as a tick on every clock.

Reset
REQ-021 SHALL, while resetn=0, force out_level=0, prev_level=0, key_pulse=0, pending=0, button=0, debounce counter=0, and repeat counter=0, regardless of clock.
REQ-022 SHALL discard any partial debounce count or pending event when reset asserts mid-operation; after release, key_pulse asserts only after in_sync is 1 for DEBOUNCE_CYCLES clocks.

Configuration
REQ-023 SHALL support macro BUTTON_EVENT_PIPELINE_AUTOREPEAT_EN; when undefined, behaviour is exactly REQ-011..REQ-022 and no repeat counter is synthesized.
REQ-024 SHALL, when BUTTON_EVENT_PIPELINE_AUTOREPEAT_EN is defined, count clocks while out_level=1 and feed the pending flag an extra event REPEAT_DELAY clocks after the rise, then every REPEAT_PERIOD clocks while held.
REQ-025 SHALL, with the macro defined, clear the repeat counter when out_level falls and never output repeat events on key_pulse.

Verification
REQ-026 SHALL pass this case: reset, then in_sync=1 for 2 clocks, 0 for 1, 1 for 3, 0 for 1, 1 for 50 -> out_level rises 16 clocks into the final high run; exactly one key_pulse occurs.
REQ-027 SHALL pass this case: tick every 100 clocks; key_pulse at clock 30 after a tick -> button=1 for one clock following the next tick; no other button pulse.
REQ-028 SHALL pass this case: two debounced presses between the same pair of ticks -> exactly one button pulse.
REQ-029 SHALL pass this case: key_pulse in the same clock as tick_input=1 -> button=1 on the next clock; pending stays 0.
REQ-030 SHALL pass this case: resetn pulsed low while pending=1 and counter=10 -> all outputs 0; no button on following ticks without a new press.
REQ-031 SHALL pass this case: with the macro defined, REPEAT_DELAY=200, REPEAT_PERIOD=50, ticks every 10 clocks, in_sync held high 400 clocks -> button pulses for the initial press, then for events at +200, +250, +300, +350 clocks after the out_level rise.
